// File: rtl/synth_pkg.sv
// synth_pkg: shared command-word layout, reserved words and issuer state encoding
package synth_pkg;
    localparam int CMD_BIT  = 15;
    localparam int MIDI_MSB = 14;
    localparam int MIDI_LSB = 8;
    localparam int VEL_MSB  = 7;
    localparam logic [15:0] STOP_ALL_WORD     = 16'h0000;
    localparam logic [15:0] IDLE_WORD_DEFAULT = 16'h7F00;
    localparam logic [6:0]  MIDI_FREE         = 7'h7F;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP} issuer_state_t;
endpackage

// File: rtl/synth_cmd_fifo.sv
// synth_cmd_fifo: synchronous FIFO with push/pop/flush, occupancy count and full/empty flags
module synth_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [W-1:0]           i_wdata,
    output logic [W-1:0]           o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic          w_push, w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];
    // A push while full is rejected even if a pop frees a slot in the same cycle
    assign w_push  = i_push && !o_full && !i_flush;
    assign w_pop   = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wptr] <= i_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/synth_cmd_issuer.sv
// synth_cmd_issuer: buffers host note commands and issues each for one cycle followed by idle filler words
module synth_cmd_issuer
    import synth_pkg::*;
#(
    parameter int          DEPTH      = 8,
    parameter int          GAP_CYCLES = 2,
    parameter logic [15:0] IDLE_WORD  = IDLE_WORD_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_wr,
    input  logic [15:0]            i_wdata,
    output logic                   o_ready,
    input  logic                   i_flush,
    input  logic                   i_pause,
    output logic [15:0]            o_data,
    output logic                   o_issue,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_drop
);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    issuer_state_t r_state;
    logic [GW-1:0] r_gap;
    logic [15:0]   w_head;
    logic          w_full, w_empty, w_can_issue, w_pop;

    synth_cmd_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (i_wr),
        .i_pop   (w_pop),
        .i_flush (i_flush),
        .i_wdata (i_wdata),
        .o_head  (w_head),
        .o_count (o_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_ready     = !w_full;
    assign w_can_issue = !w_empty && !i_pause && !i_flush;
    assign w_pop       = w_can_issue && (r_state == ST_IDLE || (r_state == ST_GAP && r_gap == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_gap   <= '0;
            o_data  <= IDLE_WORD;
            o_issue <= 1'b0;
            o_drop  <= 1'b0;
        end else begin
            o_drop <= i_wr && w_full && !i_flush;
            if (w_pop) begin
                o_data  <= w_head;
                o_issue <= 1'b1;
                r_state <= ST_ISSUE;
            end else begin
                o_data  <= IDLE_WORD;
                o_issue <= 1'b0;
                case (r_state)
                    ST_ISSUE: begin
                        r_gap   <= GAP_LAST;
                        r_state <= ST_GAP;
                    end
                    ST_GAP:
                        if (r_gap != '0) r_gap <= r_gap - GW'(1);
                        else r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule
